// File: rtl/rpn_controller.sv
// rpn_controller: reverse-Polish keystroke sequencer for the 8-entry 4-bit LIFO.
// Tracks stack occupancy itself and drives Push/Pop/Data_In from its state register.
module rpn_controller #(
    parameter int DEPTH = 8
) (
    input  logic       Clk,
    input  logic       RstN,
    input  logic       Key_Valid,
    input  logic       Key_Op,
    input  logic [3:0] Key_Data,
    input  logic [3:0] Stk_Data_Out,
    input  logic       Stk_Full,
    input  logic       Stk_NotEmpty,
    output logic [3:0] Stk_Data_In,
    output logic       Stk_Push,
    output logic       Stk_Pop,
    output logic       Busy,
    output logic [3:0] Result,
    output logic       Result_Valid,
    output logic       Error
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);
    localparam logic [DW-1:0] DTWO = DW'(2);
    localparam logic [DW-1:0] DONE = DW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_NUM,
        POP_B,
        POP_A,
        CALC,
        PUSH_RES
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] depth;
    logic [3:0]    key_q;
    logic [3:0]    b_q;
    logic [3:0]    result_q;
    logic [3:0]    calc;
    logic          err_q;
    logic          accept_num;
    logic          accept_op;
    logic          reject;

    // Stack flags act as a second guard on top of the depth counter.
    always_comb begin
        accept_num = 1'b0;
        accept_op  = 1'b0;
        reject     = 1'b0;
        if (state == IDLE && Key_Valid) begin
            if (!Key_Op) begin
                accept_num = (depth < DMAX) && !Stk_Full;
            end else begin
                accept_op = (depth >= DTWO) && Stk_NotEmpty;
            end
            reject = !(accept_num || accept_op);
        end
    end

    always_comb begin
        unique case (key_q[1:0])
            2'b00:   calc = Stk_Data_Out + b_q;
            2'b01:   calc = Stk_Data_Out - b_q;
            2'b10:   calc = Stk_Data_Out & b_q;
            default: calc = Stk_Data_Out ^ b_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept_num) begin
                    state_nxt = PUSH_NUM;
                end else if (accept_op) begin
                    state_nxt = POP_B;
                end
            end
            PUSH_NUM: state_nxt = IDLE;
            POP_B:    state_nxt = POP_A;
            POP_A:    state_nxt = CALC;
            CALC:     state_nxt = PUSH_RES;
            PUSH_RES: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= IDLE;
            depth    <= '0;
            key_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= reject;
            if (accept_num || accept_op) begin
                key_q <= Key_Data;
            end
            if (state == POP_A) begin
                b_q <= Stk_Data_Out;
            end
            if (state == CALC) begin
                result_q <= calc;
            end
            if (Stk_Push) begin
                depth <= depth + DONE;
            end else if (Stk_Pop) begin
                depth <= depth - DONE;
            end
        end
    end

    assign Stk_Push     = (state == PUSH_NUM) || (state == PUSH_RES);
    assign Stk_Pop      = (state == POP_B) || (state == POP_A);
    assign Busy         = (state != IDLE);
    assign Result_Valid = (state == PUSH_RES);
    assign Result       = result_q;
    assign Error        = err_q;
    assign Stk_Data_In  = (state == PUSH_NUM) ? key_q :
                          (state == PUSH_RES) ? result_q : 4'h0;

endmodule

// File: tb/tb_rpn_controller.sv
// tb_rpn_controller: drives keystrokes into rpn_controller attached to a LIFO
// model and compares against a keystroke-level RPN calculator model.
module tb_rpn_controller;

    logic       Clk;
    logic       RstN;
    logic       Key_Valid;
    logic       Key_Op;
    logic [3:0] Key_Data;
    logic [3:0] Stk_Data_Out;
    logic       Stk_Full;
    logic       Stk_NotEmpty;
    logic [3:0] Stk_Data_In;
    logic       Stk_Push;
    logic       Stk_Pop;
    logic       Busy;
    logic [3:0] Result;
    logic       Result_Valid;
    logic       Error;

    rpn_controller #(.DEPTH(8)) dut (
        .Clk          (Clk),
        .RstN         (RstN),
        .Key_Valid    (Key_Valid),
        .Key_Op       (Key_Op),
        .Key_Data     (Key_Data),
        .Stk_Data_Out (Stk_Data_Out),
        .Stk_Full     (Stk_Full),
        .Stk_NotEmpty (Stk_NotEmpty),
        .Stk_Data_In  (Stk_Data_In),
        .Stk_Push     (Stk_Push),
        .Stk_Pop      (Stk_Pop),
        .Busy         (Busy),
        .Result       (Result),
        .Result_Valid (Result_Valid),
        .Error        (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Board stack: Data_Out takes the popped entry on the Pop edge.
    logic [3:0] stk [8];
    int         scnt;
    logic [3:0] sdout;

    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            scnt  <= 0;
            sdout <= 4'h0;
        end else if (Stk_Push && scnt < 8) begin
            stk[scnt] <= Stk_Data_In;
            scnt      <= scnt + 1;
        end else if (Stk_Pop && scnt > 0) begin
            sdout <= stk[scnt-1];
            scnt  <= scnt - 1;
        end
    end

    assign Stk_Data_Out = sdout;
    assign Stk_Full     = (scnt == 8);
    assign Stk_NotEmpty = (scnt != 0);

    int err_tot;
    int rv_tot;
    int push_tot;
    int pop_tot;
    int viol;

    initial begin
        err_tot  = 0;
        rv_tot   = 0;
        push_tot = 0;
        pop_tot  = 0;
        viol     = 0;
    end

    always @(negedge Clk) begin
        err_tot  <= err_tot + int'(Error);
        rv_tot   <= rv_tot + int'(Result_Valid);
        push_tot <= push_tot + int'(Stk_Push);
        pop_tot  <= pop_tot + int'(Stk_Pop);
        if ((Stk_Push && Stk_Pop) || (Stk_Push && Stk_Full) ||
            (Stk_Pop && !Stk_NotEmpty)) begin
            viol <= viol + 1;
        end
    end

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference calculator: a plain list of values plus last result.
    logic [3:0] ref_q[$];
    logic [3:0] ref_result;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_din"},  Stk_Data_In, 0);
        check({tag, "_push"}, Stk_Push, 0);
        check({tag, "_pop"},  Stk_Pop, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_res"},  Result, 0);
        check({tag, "_rv"},   Result_Valid, 0);
        check({tag, "_err"},  Error, 0);
        check({tag, "_ne"},   Stk_NotEmpty, 0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #1;
        Key_Valid = 1'b0;
        RstN      = 1'b0;
        @(negedge Clk);
        #1;
        check_reset_outputs("rst");
        RstN = 1'b1;
        ref_q.delete();
        ref_result = 4'h0;
    endtask

    task automatic key(input bit op, input logic [3:0] d, input int hold);
        int         exp_busy;
        int         exp_err;
        int         exp_rv;
        int         exp_push;
        int         exp_pop;
        int         n;
        int         e0;
        int         r0;
        int         p0;
        int         q0;
        int         h;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        exp_busy = 0;
        exp_err  = 0;
        exp_rv   = 0;
        exp_push = 0;
        exp_pop  = 0;
        if (!op) begin
            if (ref_q.size() < 8) begin
                ref_q.push_back(d);
                exp_busy = 1;
                exp_push = 1;
            end else begin
                exp_err = 1;
            end
        end else if (ref_q.size() >= 2) begin
            b = ref_q.pop_back();
            a = ref_q.pop_back();
            case (d[1:0])
                2'd0:    r = a + b;
                2'd1:    r = a - b;
                2'd2:    r = a & b;
                default: r = a ^ b;
            endcase
            ref_q.push_back(r);
            ref_result = r;
            exp_busy   = 4;
            exp_rv     = 1;
            exp_push   = 1;
            exp_pop    = 2;
        end else begin
            exp_err = 1;
        end
        h = (hold > exp_busy) ? exp_busy : hold;

        @(negedge Clk);
        #1;
        e0 = err_tot;
        r0 = rv_tot;
        p0 = push_tot;
        q0 = pop_tot;
        Key_Valid = 1'b1;
        Key_Op    = op;
        Key_Data  = d;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            #1;
            Key_Valid = (i < h);
            Key_Op    = 1'($urandom);
            Key_Data  = 4'($urandom);
            if (!Busy) break;
            n++;
        end
        Key_Valid = 1'b0;

        check("busy_cycles", n, exp_busy);
        check("error_pulses", err_tot - e0, exp_err);
        check("rv_pulses", rv_tot - r0, exp_rv);
        check("push_count", push_tot - p0, exp_push);
        check("pop_count", pop_tot - q0, exp_pop);
        check("result", Result, ref_result);
        check("depth", scnt, ref_q.size());
        if (ref_q.size() > 0) begin
            check("top", stk[scnt-1], ref_q[$]);
        end
    endtask

    initial begin
        int p0;
        int q0;
        n_checks   = 0;
        n_errors   = 0;
        RstN       = 1'b0;
        Key_Valid  = 1'b0;
        Key_Op     = 1'b0;
        Key_Data   = 4'h0;
        ref_result = 4'h0;
        ref_q.delete();

        do_reset();
        key(0, 4'd3, 0);
        key(0, 4'd5, 0);
        key(1, 4'd0, 0);
        check("add_3_5", Result, 4'h8);

        do_reset();
        key(0, 4'd2, 0);
        key(0, 4'd5, 0);
        key(1, 4'd1, 0);
        check("sub_2_5", Result, 4'hd);
        key(1, 4'd2, 0);

        do_reset();
        for (int i = 1; i <= 8; i++) key(0, 4'(i), 0);
        key(0, 4'd9, 0);
        check("full_held", Stk_Full, 1);
        key(1, 4'd3, 0);
        check("xor_8_7", Result, 4'hf);
        check("xor_depth", scnt, 7);

        do_reset();
        key(0, 4'd4, 0);
        key(0, 4'd6, 0);
        key(1, 4'd0, 4);
        check("busy_ignore", Result, 4'ha);

        do_reset();
        key(0, 4'd15, 0);
        key(0, 4'd1, 0);
        key(1, 4'd0, 0);
        check("add_wrap", Result, 4'h0);
        key(0, 4'd0, 0);
        key(0, 4'd1, 0);
        key(1, 4'd1, 0);
        check("sub_wrap", Result, 4'hf);

        do_reset();
        key(0, 4'd7, 0);
        key(0, 4'd9, 0);
        @(negedge Clk);
        #1;
        Key_Valid = 1'b1;
        Key_Op    = 1'b1;
        Key_Data  = 4'd0;
        @(negedge Clk);
        #1;
        Key_Valid = 1'b0;
        @(negedge Clk);
        #1;
        check("popa_pop", Stk_Pop, 1);
        RstN = 1'b0;
        #1;
        check_reset_outputs("midrst");
        p0 = push_tot;
        q0 = pop_tot;
        @(negedge Clk);
        #1;
        RstN = 1'b1;
        ref_q.delete();
        ref_result = 4'h0;
        repeat (3) @(negedge Clk);
        #1;
        check("post_rst_push", push_tot - p0, 0);
        check("post_rst_pop", pop_tot - q0, 0);
        key(0, 4'd4, 0);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 49) do_reset();
            key(($urandom_range(0, 2) == 0), 4'($urandom),
                int'($urandom_range(0, 4)));
        end

        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
